// File: rtl/conv_window_ctrl_l1.sv
// Sequencing controller for the layer-1 convolution line-buffer datapath.
// Accepts a raster pixel stream, drives the shift enable and flags complete KxK windows.
module conv_window_ctrl_l1 #(
    parameter int unsigned IMG_W = 15,
    parameter int unsigned IMG_H = 15,
    parameter int unsigned K     = 3,
    localparam int unsigned CW   = $clog2(IMG_W),
    localparam int unsigned RW   = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    input  logic          out_ready,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned COL_LAST = IMG_W - 1;
    localparam int unsigned ROW_LAST = IMG_H - 1;
    localparam int unsigned FILL     = K - 1;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_win_valid;
    logic [RW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;
    logic          r_busy;
    logic          r_done;

    logic w_in_ready;
    logic w_shift;
    logic w_col_last;
    logic w_row_last;
    logic w_last_pix;
    logic w_complete;
    logic w_consume;

    // Stall while an unconsumed window is held; abort blocks acceptance outright.
    assign w_in_ready = (r_state == ST_RUN) & (~r_win_valid | out_ready) & ~abort;
    assign w_shift    = in_valid & w_in_ready;
    assign w_col_last = (r_col == CW'(COL_LAST));
    assign w_row_last = (r_row == RW'(ROW_LAST));
    assign w_last_pix = w_shift & w_col_last & w_row_last;
    assign w_complete = w_shift & (r_row >= RW'(FILL)) & (r_col >= CW'(FILL));
    assign w_consume  = (r_state == ST_DRAIN) & r_win_valid & out_ready;

    // Frame FSM, raster position counters and window flag/indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_win_valid <= 1'b0;
                r_col       <= '0;
                r_row       <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_col   <= '0;
                            r_row   <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (w_last_pix) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (w_consume) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase

                // The final pixel leaves the counters parked; entry to RUN clears them.
                if (w_shift && !w_last_pix) begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= r_row + RW'(1);
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end

                if (w_complete) begin
                    r_win_valid <= 1'b1;
                    r_win_row   <= r_row - RW'(FILL);
                    r_win_col   <= r_col - CW'(FILL);
                end else if (out_ready) begin
                    r_win_valid <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign shift_en  = w_shift;
    assign win_valid = r_win_valid;
    assign win_row   = r_win_row;
    assign win_col   = r_win_col;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_conv_window_ctrl_l1.sv
// Randomised bench for conv_window_ctrl_l1 against a pixel-index reference model.
module tb_conv_window_ctrl_l1;

    localparam int unsigned W  = 15;
    localparam int unsigned H  = 15;
    localparam int unsigned K  = 3;
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned RW = $clog2(H);
    localparam int          N_WIN  = (H - K + 1) * (W - K + 1);
    localparam int          N_PIX  = W * H;
    localparam int          FIRST_LAT = (K - 1) * W + K;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic          shift_en;
    logic          out_ready;
    logic          win_valid;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          busy;
    logic          done;

    conv_window_ctrl_l1 #(.IMG_W(W), .IMG_H(H), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .shift_en(shift_en),
        .out_ready(out_ready), .win_valid(win_valid), .win_row(win_row),
        .win_col(win_col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame phase (0 idle, 1 accepting, 2 draining) and pixel index.
    int m_phase = 0;
    int m_pix   = 0;
    int m_wr    = 0;
    int m_wc    = 0;
    bit m_wv    = 1'b0;
    bit m_done  = 1'b0;

    // Observations of the DUT within one frame.
    int            dut_shifts = 0;
    int            dut_wins   = 0;
    int            first_lat  = -1;
    int            done_cnt   = 0;
    bit            p_wv       = 1'b0;
    logic [RW-1:0] p_wr       = '0;
    logic [CW-1:0] p_wc       = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pix   = 0;
        m_wr    = 0;
        m_wc    = 0;
        m_wv    = 1'b0;
        m_done  = 1'b0;
        p_wv    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_in_ready"},  in_ready,  0);
        check_eq({tag, "_shift_en"},  shift_en,  0);
        check_eq({tag, "_win_valid"}, win_valid, 0);
        check_eq({tag, "_win_row"},   win_row,   0);
        check_eq({tag, "_win_col"},   win_col,   0);
        check_eq({tag, "_busy"},      busy,      0);
        check_eq({tag, "_done"},      done,      0);
    endtask

    // One clock: drive inputs, check handshake, advance model, check registered outputs.
    task automatic step(input logic s, input logic a, input logic v, input logic o);
        bit exp_rdy;
        bit acc;
        int r;
        int c;
        @(negedge clk);
        start = s; abort = a; in_valid = v; out_ready = o;
        #1;
        exp_rdy = (m_phase == 1) && (!m_wv || o) && !a;
        acc     = exp_rdy && v;
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("shift_en", shift_en, acc);
        if (shift_en === 1'b1) dut_shifts++;

        m_done = 1'b0;
        if (a) begin
            m_phase = 0;
            m_wv    = 1'b0;
            m_pix   = 0;
        end else if (m_phase == 0) begin
            if (s) begin
                m_phase = 1;
                m_pix   = 0;
            end
        end else if (m_phase == 1) begin
            if (acc) begin
                r = m_pix / W;
                c = m_pix % W;
                m_pix++;
                if (r >= K - 1 && c >= K - 1) begin
                    m_wv = 1'b1;
                    m_wr = r - (K - 1);
                    m_wc = c - (K - 1);
                end else if (o) begin
                    m_wv = 1'b0;
                end
                if (m_pix == N_PIX) m_phase = 2;
            end else if (o) begin
                m_wv = 1'b0;
            end
        end else begin
            if (m_wv && o) begin
                m_phase = 0;
                m_wv    = 1'b0;
                m_done  = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        check_eq("win_valid", win_valid, m_wv);
        check_eq("busy", busy, (m_phase != 0));
        check_eq("done", done, m_done);
        check_eq("win_row", win_row, m_wr);
        check_eq("win_col", win_col, m_wc);
        if (win_valid === 1'b1 && (!p_wv || win_row != p_wr || win_col != p_wc)) begin
            dut_wins++;
            if (dut_wins == 1) first_lat = dut_shifts;
        end
        p_wv = (win_valid === 1'b1);
        p_wr = win_row;
        p_wc = win_col;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic run_frame(input int bubble_pct, input bit do_bp, input int abort_at,
                             input bit poke_start);
        int  bp_left = 0;
        bit  bp_done = 1'b0;
        bit  aborted = 1'b0;
        int  budget  = 0;
        logic v, o, a, s;
        dut_shifts = 0;
        dut_wins   = 0;
        first_lat  = -1;
        done_cnt   = 0;
        p_wv       = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        while (m_phase != 0 && budget < 5000) begin
            budget++;
            v = ($urandom_range(99) >= bubble_pct);
            if (do_bp && !bp_done && m_wv && m_wr == 4 && m_wc == 7) begin
                bp_left = 5;
                bp_done = 1'b1;
            end
            o = (bp_left == 0);
            if (bp_left > 0) bp_left--;
            a = (abort_at >= 0 && m_phase == 1 && m_pix == abort_at);
            if (a) aborted = 1'b1;
            s = poke_start && ($urandom_range(7) == 0);
            step(s, a, v, o);
        end
        check_eq("frame_timeout", (budget < 5000), 1);
        if (aborted) begin
            check_eq("abort_done_cnt", done_cnt, 0);
            check_eq("abort_busy", busy, 0);
            check_eq("abort_win_valid", win_valid, 0);
        end else begin
            check_eq("win_count", dut_wins, N_WIN);
            check_eq("first_win_lat", first_lat, FIRST_LAT);
            check_eq("shift_count", dut_shifts, N_PIX);
            check_eq("done_count", done_cnt, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(0,  1'b0, -1, 1'b0);
        run_frame(0,  1'b1, -1, 1'b0);
        run_frame(50, 1'b0, -1, 1'b0);
        run_frame(50, 1'b0, -1, 1'b1);
        run_frame(0,  1'b0, 6 * W + 9, 1'b0);
        run_frame(0,  1'b0, -1, 1'b0);

        // Asynchronous reset in the middle of a frame.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (40) step(1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // start together with abort in IDLE must leave the controller idle.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("start_abort_idle", busy, 0);
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b1);

        run_frame(25, 1'b0, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
